// File: rtl/cla_seq_adder_if.sv
// Request/result bus of the sequential nibble-serial carry-lookahead adder.
interface cla_seq_adder_if #(
   parameter int unsigned WIDTH = 16
);
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             carryInput;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] sum;
   logic             carryOutput;

   modport master (
      output start, a, b, carryInput,
      input  busy, done, sum, carryOutput
   );

   modport slave (
      input  start, a, b, carryInput,
      output busy, done, sum, carryOutput
   );
endinterface

// File: rtl/cla_seq_adder.sv
// Sequential adder: one 4-bit carry-lookahead slice reused per nibble, LSB first.
// Fixed latency of WIDTH/4 cycles from start acceptance to the done pulse.
module cla_seq_adder #(
   parameter int unsigned WIDTH = 16
) (
   input logic            clk,
   input logic            rst,
   cla_seq_adder_if.slave bus
);
   localparam int unsigned NSLICE = WIDTH / 4;
   localparam int unsigned CW     = $clog2(NSLICE + 1);
   localparam int unsigned LAST   = NSLICE - 1;

   typedef enum logic {IDLE, RUN} state_t;

   state_t           state;
   logic [WIDTH-1:0] opa;
   logic [WIDTH-1:0] opb;
   logic [WIDTH-1:0] partial;
   logic [CW-1:0]    cnt;
   logic             carry;

   logic [3:0]       na_c;
   logic [3:0]       nb_c;
   logic [3:0]       g_c;
   logic [3:0]       p_c;
   logic [3:0]       c_c;
   logic [3:0]       ns_c;
   logic             nco_c;
   logic [WIDTH-1:0] partial_upd_c;

   // Nibble selected by the counter feeds the single lookahead slice
   always_comb begin
      na_c  = 4'(opa >> {cnt, 2'b00});
      nb_c  = 4'(opb >> {cnt, 2'b00});
      g_c   = na_c & nb_c;
      p_c   = na_c ^ nb_c;
      c_c[0] = carry;
      c_c[1] = g_c[0] | (p_c[0] & carry);
      c_c[2] = g_c[1] | (p_c[1] & g_c[0]) | (p_c[1] & p_c[0] & carry);
      c_c[3] = g_c[2] | (p_c[2] & g_c[1]) | (p_c[2] & p_c[1] & g_c[0])
             | (p_c[2] & p_c[1] & p_c[0] & carry);
      nco_c  = g_c[3] | (p_c[3] & g_c[2]) | (p_c[3] & p_c[2] & g_c[1])
             | (p_c[3] & p_c[2] & p_c[1] & g_c[0])
             | (p_c[3] & p_c[2] & p_c[1] & p_c[0] & carry);
      ns_c   = p_c ^ c_c;
   end

   // Partial result with the current nibble merged in
   always_comb begin
      partial_upd_c = partial;
      for (int i = 0; i < int'(NSLICE); i++) begin
         if (cnt == CW'(i)) partial_upd_c[4*i +: 4] = ns_c;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state           <= IDLE;
         opa             <= '0;
         opb             <= '0;
         partial         <= '0;
         cnt             <= '0;
         carry           <= 1'b0;
         bus.busy        <= 1'b0;
         bus.done        <= 1'b0;
         bus.sum         <= '0;
         bus.carryOutput <= 1'b0;
      end else begin
         bus.done <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.start) begin
                  opa      <= bus.a;
                  opb      <= bus.b;
                  carry    <= bus.carryInput;
                  cnt      <= '0;
                  partial  <= '0;
                  bus.busy <= 1'b1;
                  state    <= RUN;
               end
            end
            RUN: begin
               partial <= partial_upd_c;
               carry   <= nco_c;
               cnt     <= cnt + CW'(1);
               // Last nibble: publish result and return to idle
               if (cnt == CW'(LAST)) begin
                  bus.sum         <= partial_upd_c;
                  bus.carryOutput <= nco_c;
                  bus.done        <= 1'b1;
                  bus.busy        <= 1'b0;
                  state           <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_cla_seq_adder.sv
// Directed self-checking bench for cla_seq_adder (WIDTH=16).
module tb_cla_seq_adder;
   logic clk = 1'b0;
   logic rst;
   int   vectors = 0;
   int   miscompares = 0;

   cla_seq_adder_if #(.WIDTH(16)) bus ();

   cla_seq_adder #(.WIDTH(16)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic launch(input logic [15:0] av, input logic [15:0] bv, input logic ci);
      bus.a          = av;
      bus.b          = bv;
      bus.carryInput = ci;
      bus.start      = 1'b1;
      tick();
      bus.start      = 1'b0;
   endtask

   // Counts cycles until done is seen, bounded at 20
   task automatic wait_done(output int cyc);
      cyc = 0;
      while (bus.done !== 1'b1 && cyc < 20) begin
         tick();
         cyc++;
      end
   endtask

   task automatic test_reset();
      rst       = 1'b1;
      bus.start = 1'b1;
      bus.a     = 16'h1111;
      bus.b     = 16'h2222;
      bus.carryInput = 1'b1;
      tick();
      tick();
      vectors++;
      if ({bus.busy, bus.done, bus.sum, bus.carryOutput} !== {1'b0, 1'b0, 16'h0000, 1'b0}) begin
         miscompares++;
         $display("FAIL reset: busy=%b done=%b sum=%h co=%b expected 0 0 0000 0",
                  bus.busy, bus.done, bus.sum, bus.carryOutput);
      end
      bus.start = 1'b0;
      rst       = 1'b0;
      tick();
   endtask

   task automatic test_basic();
      launch(16'h1234, 16'h4321, 1'b0);
      for (int k = 1; k <= 4; k++) begin
         vectors++;
         if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_run%0d: busy=%b done=%b expected 1 0", k, bus.busy, bus.done);
         end
         tick();
      end
      vectors++;
      if ({bus.busy, bus.done, bus.sum, bus.carryOutput} !== {1'b0, 1'b1, 16'h5555, 1'b0}) begin
         miscompares++;
         $display("FAIL basic_done: busy=%b done=%b sum=%h co=%b expected 0 1 5555 0",
                  bus.busy, bus.done, bus.sum, bus.carryOutput);
      end
      tick();
      vectors++;
      if (bus.done !== 1'b0 || bus.sum !== 16'h5555) begin
         miscompares++;
         $display("FAIL basic_hold: done=%b sum=%h expected 0 5555", bus.done, bus.sum);
      end
   endtask

   task automatic test_carry_ripple();
      int cyc;
      launch(16'hFFFF, 16'h0001, 1'b0);
      wait_done(cyc);
      vectors++;
      if (cyc != 4 || bus.sum !== 16'h0000 || bus.carryOutput !== 1'b1) begin
         miscompares++;
         $display("FAIL ripple_plus1: cyc=%0d sum=%h co=%b expected 4 0000 1", cyc, bus.sum, bus.carryOutput);
      end
      tick();
      launch(16'hFFFF, 16'hFFFF, 1'b1);
      tick();
      vectors++;
      if (bus.sum !== 16'h0000 || bus.carryOutput !== 1'b1) begin
         miscompares++;
         $display("FAIL ripple_midhold: sum=%h co=%b expected 0000 1", bus.sum, bus.carryOutput);
      end
      wait_done(cyc);
      vectors++;
      if (cyc != 3 || bus.sum !== 16'hFFFF || bus.carryOutput !== 1'b1) begin
         miscompares++;
         $display("FAIL ripple_allones: cyc=%0d sum=%h co=%b expected 3 ffff 1", cyc, bus.sum, bus.carryOutput);
      end
      tick();
   endtask

   task automatic test_back_to_back();
      int cyc;
      launch(16'h0F0F, 16'h0101, 1'b0);
      bus.a     = 16'hAAAA;
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      wait_done(cyc);
      vectors++;
      if (cyc != 3 || bus.sum !== 16'h1010 || bus.carryOutput !== 1'b0 || bus.busy !== 1'b0) begin
         miscompares++;
         $display("FAIL b2b_first: cyc=%0d sum=%h co=%b busy=%b expected 3 1010 0 0",
                  cyc, bus.sum, bus.carryOutput, bus.busy);
      end
      launch(16'h0002, 16'h0003, 1'b0);
      vectors++;
      if (bus.done !== 1'b0 || bus.busy !== 1'b1) begin
         miscompares++;
         $display("FAIL b2b_accept: done=%b busy=%b expected 0 1", bus.done, bus.busy);
      end
      wait_done(cyc);
      vectors++;
      if (cyc != 4 || bus.sum !== 16'h0005 || bus.carryOutput !== 1'b0) begin
         miscompares++;
         $display("FAIL b2b_second: cyc=%0d sum=%h co=%b expected 4 0005 0", cyc, bus.sum, bus.carryOutput);
      end
      tick();
   endtask

   task automatic test_reset_abort();
      int cyc;
      int pulses = 0;
      launch(16'h9999, 16'h9999, 1'b0);
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      for (int k = 0; k < 6; k++) begin
         if (bus.done === 1'b1) pulses++;
         tick();
      end
      vectors++;
      if (pulses != 0 || bus.sum !== 16'h0000 || bus.busy !== 1'b0 || bus.carryOutput !== 1'b0) begin
         miscompares++;
         $display("FAIL abort: pulses=%0d sum=%h busy=%b co=%b expected 0 0000 0 0",
                  pulses, bus.sum, bus.busy, bus.carryOutput);
      end
      launch(16'h9999, 16'h9999, 1'b0);
      wait_done(cyc);
      vectors++;
      if (cyc != 4 || bus.sum !== 16'h3332 || bus.carryOutput !== 1'b1) begin
         miscompares++;
         $display("FAIL abort_rerun: cyc=%0d sum=%h co=%b expected 4 3332 1", cyc, bus.sum, bus.carryOutput);
      end
      tick();
   endtask

   task automatic test_operand_change();
      launch(16'hC3A7, 16'h5E69, 1'b1);
      for (int k = 0; k < 4; k++) begin
         bus.a          = 16'h0F00 + 16'(k * 16'h1111);
         bus.b          = ~bus.a;
         bus.carryInput = ~bus.carryInput;
         tick();
      end
      vectors++;
      if (bus.done !== 1'b1 || bus.sum !== 16'h2211 || bus.carryOutput !== 1'b1) begin
         miscompares++;
         $display("FAIL operand_change: done=%b sum=%h co=%b expected 1 2211 1",
                  bus.done, bus.sum, bus.carryOutput);
      end
      tick();
   endtask

   initial begin
      rst            = 1'b1;
      bus.start      = 1'b0;
      bus.a          = '0;
      bus.b          = '0;
      bus.carryInput = 1'b0;
      test_reset();
      test_basic();
      test_carry_ripple();
      test_back_to_back();
      test_reset_abort();
      test_operand_change();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
